ahb_boot_loader: RTL and testbench
==================================

# ahb_boot_loader

AHB-Lite single-master boot loader that sits directly upstream of the on-chip AHB memory slave. It receives a byte stream (length header, little-endian words, checksum trailer), packs bytes into 32-bit words, and writes them into memory through non-pipelined single word transfers. It holds the CPU in reset until the image is loaded and verified.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of the first word written; must be word aligned.
- MAX_WORDS, 4096: largest accepted image length in words (16 KB default memory).

- HCLK  in  1  system clock; all logic is on the rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte; a transfer happens on an edge where rx_valid & rx_ready.
- HADDR  out  32  AHB address.
- HTRANS  out  2  2'b00 IDLE or 2'b10 NONSEQ only.
- HWRITE  out  1  1 while NONSEQ is driven, else 0.
- HSIZE  out  3  constant 3'b010 (word).
- HWDATA  out  32  write data, valid in the data phase.
- HREADY  in  1  bus ready, from the interconnect.
- HRESP  in  1  slave error response.
- cpu_hold  out  1  1 keeps the CPU in reset.
- boot_done  out  1  sticky; image loaded and checksum good.
- boot_error  out  1  sticky; failure.

## Operation
- All outputs are registered. Reset values: rx_ready=0, HADDR=BASE_ADDR, HTRANS=IDLE, HWRITE=0, HWDATA=0, cpu_hold=1, boot_done=0, boot_error=0. The state is LEN.
- Stream format: 4 length bytes (word count N, little-endian), then N×4 data bytes (little-endian words), then 4 checksum bytes. The checksum is the 32-bit sum of all N words, modulo 2^32.
- States:
  - LEN: rx_ready=1; collect 4 bytes. After the 4th byte:
    - N > MAX_WORDS → ERROR.
    - N = 0 → SUM.
    - otherwise → COLLECT.
  - COLLECT: rx_ready=1; a byte counter 0..3 places byte k into bits [8k+7:8k]. After the 4th byte → ADDR, and rx_ready=0 from the next cycle.
  - ADDR: HTRANS=NONSEQ, HWRITE=1, HADDR=BASE_ADDR+4×idx. On an edge with HREADY=1 → DATA.
  - DATA: HTRANS=IDLE, HWRITE=0, HWDATA=assembled word. On an edge with HREADY=1:
    - HRESP=1 → ERROR.
    - otherwise add the word to the running sum and increment idx.
    - idx+1 = N → SUM; else → COLLECT.
  - SUM: rx_ready=1; collect 4 trailer bytes. Trailer equals the running sum → DONE; else → ERROR.
  - DONE: cpu_hold=0, boot_done=1, rx_ready=0, bus IDLE. Terminal until reset.
  - ERROR: boot_error=1, cpu_hold=1, rx_ready=0, bus IDLE. Terminal until reset.
- idx is 32 bits wide. The address adder wraps modulo 2^32 with no error.
- Reset asserted in any state immediately forces the reset values and discards partial words and sums.

## Timing
- Address phase: HADDR, HTRANS and HWRITE are stable from entry to ADDR until the edge where HREADY=1.
- Data phase: HWDATA is stable until the edge where HREADY=1. It is held after that until the next data phase.
- No back-to-back pipelining: only one transfer is ever outstanding, and IDLE is driven during every data phase.
- Best-case cost per word is 6 cycles: 4 byte cycles, 1 address cycle, 1 data cycle. Each HREADY=0 cycle adds one.
- rx_valid while rx_ready=0 is ignored. The source must hold the byte, per valid/ready rules.
- boot_done/boot_error rise on the edge that completes the final trailer byte (or the failing event). cpu_hold falls on the same edge.

## Test plan
- **Single word.** Send 01 00 00 00, 44 33 22 11, 44 33 22 11 with HREADY=1.
  - Required: one NONSEQ at HADDR=BASE_ADDR, then HWDATA=0x11223344.
  - boot_done=1 and cpu_hold=0 after the last byte.
- **Wait states.** N=3 with HREADY=0 for 2 cycles in every address and data phase.
  - Required: HADDR BASE, +4, +8 each held stable; HWDATA held stable.
  - No extra transfers; done after a correct sum.
- **Zero length.** N=0 with a trailer of 00 00 00 00.
  - Required: no NONSEQ ever driven; boot_done=1.
- **Oversize length.** N=MAX_WORDS+1.
  - Required: boot_error=1 on the 4th length byte; rx_ready=0; HTRANS stays IDLE; cpu_hold=1.
- **Bad checksum or bus error.**
  - N=2 with a wrong trailer → both writes complete, then boot_error=1 and cpu_hold=1.
  - Separately, HRESP=1 with HREADY=1 on the 2nd data phase → ERROR immediately; no trailer bytes accepted.
- **Reset mid-operation.** Assert HRESET during the 2nd write's address phase.
  - Required: HTRANS=IDLE and rx_ready=0 without waiting for a clock edge.
  - After release, a fresh single-word image loads correctly at BASE_ADDR.

Source files
------------

// File: rtl/ahb_boot_loader_if.sv
// ----------------------------------------------------------------------------
// ahb_boot_loader_if
// Purpose: groups the byte-stream handshake, the AHB-Lite master signals and
//          the boot status outputs of the boot loader.
// Signals:
//   rx_data/rx_valid/rx_ready   byte stream, valid/ready handshake
//   HADDR/HTRANS/HWRITE/HSIZE   AHB address phase (driven by the loader)
//   HWDATA                      AHB write data phase
//   HREADY/HRESP                AHB slave response
//   cpu_hold/boot_done/boot_error  boot status
// Modports: master = boot loader, slave = stream source / bus / system side.
// ----------------------------------------------------------------------------
interface ahb_boot_loader_if;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 8;

   logic [BW-1:0] rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [AW-1:0] HADDR;
   logic [1:0]    HTRANS;
   logic          HWRITE;
   logic [2:0]    HSIZE;
   logic [DW-1:0] HWDATA;
   logic          HREADY;
   logic          HRESP;
   logic          cpu_hold;
   logic          boot_done;
   logic          boot_error;

   modport master (
      input  rx_data, rx_valid, HREADY, HRESP,
      output rx_ready, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
             cpu_hold, boot_done, boot_error
   );

   modport slave (
      output rx_data, rx_valid, HREADY, HRESP,
      input  rx_ready, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
             cpu_hold, boot_done, boot_error
   );
endinterface

// File: rtl/ahb_boot_loader.sv
// ----------------------------------------------------------------------------
// ahb_boot_loader
// Purpose: receives a boot image as a byte stream (4-byte LE word count,
//          N LE data words, 4-byte LE checksum), writes each word to memory
//          with a single non-pipelined AHB-Lite write, verifies the 32-bit
//          sum and then releases the CPU from reset.
// Ports:
//   HCLK     system clock, rising edge
//   HRESET   asynchronous active-high reset
//   bus      ahb_boot_loader_if.master (stream handshake, AHB master, status)
// Parameters:
//   BASE_ADDR  word-aligned byte address of the first word
//   MAX_WORDS  largest accepted image length in words
// ----------------------------------------------------------------------------
module ahb_boot_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 4096
) (
   input  logic              HCLK,
   input  logic              HRESET,
   ahb_boot_loader_if.master bus
);
   localparam int unsigned DW   = 32;
   localparam int unsigned CW   = 2;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   typedef enum logic [2:0] {
      S_LEN,
      S_COLLECT,
      S_ADDR,
      S_DATA,
      S_SUM,
      S_DONE,
      S_ERROR
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [DW-1:0]   r_shift,    w_shift_nxt;
   logic [CW-1:0]   r_byte_cnt, w_byte_cnt_nxt;
   logic [DW-1:0]   r_len,      w_len_nxt;
   logic [DW-1:0]   r_idx,      w_idx_nxt;
   logic [DW-1:0]   r_sum,      w_sum_nxt;
   logic [DW-1:0]   r_haddr,    w_haddr_nxt;
   logic [DW-1:0]   r_hwdata,   w_hwdata_nxt;
   logic            r_rx_ready;
   logic [1:0]      r_htrans;
   logic            r_hwrite;
   logic            r_cpu_hold;
   logic            r_boot_done;
   logic            r_boot_error;

   logic            w_accept;
   logic            w_last_byte;
   logic [DW-1:0]   w_word;
   logic [DW-1:0]   w_idx_inc;

   // Byte k of a group lands in bits [8k+7:8k]: shift each byte in from the top.
   assign w_accept    = r_rx_ready & bus.rx_valid;
   assign w_last_byte = w_accept & (r_byte_cnt == CW'(3));
   assign w_word      = {bus.rx_data, r_shift[DW-1:8]};
   assign w_idx_inc   = r_idx + DW'(1);

   // Next-state and datapath next values
   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_byte_cnt_nxt = r_byte_cnt;
      w_len_nxt      = r_len;
      w_idx_nxt      = r_idx;
      w_sum_nxt      = r_sum;
      w_haddr_nxt    = r_haddr;
      w_hwdata_nxt   = r_hwdata;

      // rx_ready is only high in LEN/COLLECT/SUM, so w_accept implies one of those
      if (w_accept) begin
         w_shift_nxt    = w_word;
         w_byte_cnt_nxt = r_byte_cnt + CW'(1);
      end

      case (r_state)
         S_LEN: begin
            if (w_last_byte) begin
               w_len_nxt = w_word;
               if (w_word > 32'(MAX_WORDS)) begin
                  w_state_nxt = S_ERROR;
               end else if (w_word == '0) begin
                  w_state_nxt = S_SUM;
               end else begin
                  w_state_nxt = S_COLLECT;
               end
            end
         end
         S_COLLECT: begin
            if (w_last_byte) begin
               w_state_nxt = S_ADDR;
               w_haddr_nxt = BASE_ADDR + {r_idx[DW-3:0], 2'b00};
            end
         end
         S_ADDR: begin
            if (bus.HREADY) begin
               w_state_nxt  = S_DATA;
               w_hwdata_nxt = r_shift;
            end
         end
         S_DATA: begin
            if (bus.HREADY) begin
               if (bus.HRESP) begin
                  w_state_nxt = S_ERROR;
               end else begin
                  w_sum_nxt   = r_sum + r_hwdata;
                  w_idx_nxt   = w_idx_inc;
                  w_state_nxt = (w_idx_inc == r_len) ? S_SUM : S_COLLECT;
               end
            end
         end
         S_SUM: begin
            if (w_last_byte) begin
               w_state_nxt = (w_word == r_sum) ? S_DONE : S_ERROR;
            end
         end
         S_DONE:  w_state_nxt = S_DONE;
         S_ERROR: w_state_nxt = S_ERROR;
         default: w_state_nxt = S_ERROR;
      endcase
   end

   // State, datapath and registered outputs (outputs follow the next state)
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_state      <= S_LEN;
         r_shift      <= '0;
         r_byte_cnt   <= '0;
         r_len        <= '0;
         r_idx        <= '0;
         r_sum        <= '0;
         r_haddr      <= BASE_ADDR;
         r_hwdata     <= '0;
         r_rx_ready   <= 1'b0;
         r_htrans     <= HTRANS_IDLE;
         r_hwrite     <= 1'b0;
         r_cpu_hold   <= 1'b1;
         r_boot_done  <= 1'b0;
         r_boot_error <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_shift      <= w_shift_nxt;
         r_byte_cnt   <= w_byte_cnt_nxt;
         r_len        <= w_len_nxt;
         r_idx        <= w_idx_nxt;
         r_sum        <= w_sum_nxt;
         r_haddr      <= w_haddr_nxt;
         r_hwdata     <= w_hwdata_nxt;
         r_rx_ready   <= (w_state_nxt == S_LEN) || (w_state_nxt == S_COLLECT) ||
                         (w_state_nxt == S_SUM);
         r_htrans     <= (w_state_nxt == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
         r_hwrite     <= (w_state_nxt == S_ADDR);
         r_cpu_hold   <= (w_state_nxt != S_DONE);
         r_boot_done  <= (w_state_nxt == S_DONE);
         r_boot_error <= (w_state_nxt == S_ERROR);
      end
   end

   assign bus.rx_ready   = r_rx_ready;
   assign bus.HADDR      = r_haddr;
   assign bus.HTRANS     = r_htrans;
   assign bus.HWRITE     = r_hwrite;
   assign bus.HSIZE      = HSIZE_WORD;
   assign bus.HWDATA     = r_hwdata;
   assign bus.cpu_hold   = r_cpu_hold;
   assign bus.boot_done  = r_boot_done;
   assign bus.boot_error = r_boot_error;
endmodule

// File: tb/tb_ahb_boot_loader.sv
// ----------------------------------------------------------------------------
// tb_ahb_boot_loader
// Purpose: self-checking bench for ahb_boot_loader. Images are built from
// random words, the expected writes and outcome come from a stream-level
// model; a negedge bus agent drives HREADY/HRESP and records transfers.
// ----------------------------------------------------------------------------
module tb_ahb_boot_loader;
   localparam logic [31:0] BASE = 32'hFFFF_FFF8;
   localparam int unsigned MAXW = 16;

   logic HCLK   = 1'b0;
   logic HRESET = 1'b1;
   always #5 HCLK = ~HCLK;

   ahb_boot_loader_if bus ();

   ahb_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;
   int hready_mode = 0;   // 0: always ready, 1: random, 2: two wait cycles per phase
   int err_at = -1;       // data phase index that gets HRESP=1, -1 for none
   logic [31:0] obs_addr[$];
   logic [31:0] obs_data[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bus agent: samples outputs and picks the response for the coming edge
   initial begin
      bit          in_data;
      bit          pend_a;
      bit          pend_d;
      bit          r;
      int          wcnt;
      int          dcnt;
      logic [31:0] pa;
      logic [31:0] pd;
      in_data = 0; pend_a = 0; pend_d = 0; wcnt = 0; dcnt = 0; pa = '0; pd = '0;
      bus.HREADY = 1'b1;
      bus.HRESP  = 1'b0;
      forever begin
         @(negedge HCLK);
         if (HRESET) begin
            in_data = 0; pend_a = 0; pend_d = 0; wcnt = 0; dcnt = 0;
            bus.HREADY = 1'b1;
            bus.HRESP  = 1'b0;
         end else begin
            if (pend_a) begin
               chk("addr_held", bus.HADDR, pa);
               chk("nonseq_held", 32'(bus.HTRANS), 32'h2);
            end
            if (pend_d) chk("wdata_held", bus.HWDATA, pd);
            if (in_data) chk("idle_in_data", 32'(bus.HTRANS), 32'h0);
            chk("hwrite_rule", 32'(bus.HWRITE), 32'(bus.HTRANS == 2'b10));
            case (hready_mode)
               0:       r = 1'b1;
               1:       r = ($urandom % 3) != 0;
               default: r = !((bus.HTRANS == 2'b10) || in_data) || (wcnt >= 2);
            endcase
            bus.HREADY = r;
            bus.HRESP  = in_data && r && (dcnt == err_at);
            pend_a = 0;
            pend_d = 0;
            if (bus.HTRANS == 2'b10) begin
               if (r) begin obs_addr.push_back(bus.HADDR); in_data = 1; wcnt = 0; end
               else begin pend_a = 1; pa = bus.HADDR; wcnt++; end
            end else if (in_data) begin
               if (r) begin obs_data.push_back(bus.HWDATA); in_data = 0; wcnt = 0; dcnt++; end
               else begin pend_d = 1; pd = bus.HWDATA; wcnt++; end
            end
         end
      end
   end

   task automatic do_reset();
      HRESET = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      @(negedge HCLK);
      @(negedge HCLK);
      chk("rst_rx_ready", 32'(bus.rx_ready), 32'h0);
      chk("rst_haddr", bus.HADDR, BASE);
      chk("rst_htrans", 32'(bus.HTRANS), 32'h0);
      chk("rst_hwrite", 32'(bus.HWRITE), 32'h0);
      chk("rst_hsize", 32'(bus.HSIZE), 32'h2);
      chk("rst_hwdata", bus.HWDATA, 32'h0);
      chk("rst_cpu_hold", 32'(bus.cpu_hold), 32'h1);
      chk("rst_boot_done", 32'(bus.boot_done), 32'h0);
      chk("rst_boot_error", 32'(bus.boot_error), 32'h0);
      HRESET = 1'b0;
      obs_addr.delete();
      obs_data.delete();
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic send_byte(input logic [7:0] b);
      int n;
      repeat ($urandom_range(0, 1)) @(negedge HCLK);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      n = 0;
      while (bus.rx_ready !== 1'b1 && n < 400) begin
         @(negedge HCLK);
         n++;
      end
      if (n >= 400) chk("rx_ready_timeout", 32'(bus.rx_ready), 32'h1);
      else @(negedge HCLK);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
   endtask

   task automatic run_image(input int n, input bit bad, input int err_k, input int mode,
                            input bit fix0, input logic [31:0] w0);
      logic [31:0] words[$];
      logic [7:0]  stream[$];
      logic [31:0] sum, trailer, w, nn;
      int          n_acc, n_xfer, t;
      bit          exp_done;
      sum = '0;
      for (int i = 0; i < n; i++) begin
         w = (fix0 && i == 0) ? w0 : $urandom;
         words.push_back(w);
         sum = sum + w;
      end
      trailer = bad ? (sum ^ (32'h1 << $urandom_range(0, 31))) : sum;
      nn = 32'(n);
      for (int b = 0; b < 4; b++) stream.push_back(nn[8*b +: 8]);
      for (int i = 0; i < n; i++) begin
         w = words[i];
         for (int b = 0; b < 4; b++) stream.push_back(w[8*b +: 8]);
      end
      for (int b = 0; b < 4; b++) stream.push_back(trailer[8*b +: 8]);

      // Stream-level expectations
      if (n > int'(MAXW)) begin
         n_acc = 4; n_xfer = 0; exp_done = 0;
      end else if (err_k >= 0) begin
         n_acc = 4 + 4 * (err_k + 1); n_xfer = err_k + 1; exp_done = 0;
      end else begin
         n_acc = stream.size(); n_xfer = n; exp_done = !bad;
      end

      hready_mode = mode;
      err_at      = err_k;
      do_reset();
      for (int i = 0; i < n_acc; i++) send_byte(stream[i]);

      if (err_k >= 0) begin
         t = 0;
         #1;
         while (obs_data.size() < n_xfer && t < 400) begin
            @(negedge HCLK); #1; t++;
         end
         @(posedge HCLK); #1;
         chk("hresp_error_edge", 32'(bus.boot_error), 32'h1);
         @(negedge HCLK);
      end else begin
         chk("final_edge_done", 32'(bus.boot_done), 32'(exp_done));
         chk("final_edge_error", 32'(bus.boot_error), 32'(!exp_done));
         chk("final_edge_cpu_hold", 32'(bus.cpu_hold), 32'(!exp_done));
      end

      repeat (3) @(negedge HCLK);
      chk("end_boot_done", 32'(bus.boot_done), 32'(exp_done));
      chk("end_boot_error", 32'(bus.boot_error), 32'(!exp_done));
      chk("end_cpu_hold", 32'(bus.cpu_hold), 32'(!exp_done));
      chk("end_rx_ready", 32'(bus.rx_ready), 32'h0);
      chk("end_htrans", 32'(bus.HTRANS), 32'h0);
      chk("n_addr", 32'(obs_addr.size()), 32'(n_xfer));
      chk("n_data", 32'(obs_data.size()), 32'(n_xfer));
      for (int i = 0; i < n_xfer && i < obs_addr.size(); i++)
         chk("xfer_addr", obs_addr[i], BASE + 32'(4 * i));
      for (int i = 0; i < n_xfer && i < obs_data.size(); i++)
         chk("xfer_data", obs_data[i], words[i]);

      // Terminal: further bytes are never taken
      bus.rx_valid = 1'b1;
      repeat (6) begin
         @(negedge HCLK);
         chk("terminal_rx_ready", 32'(bus.rx_ready), 32'h0);
      end
      bus.rx_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] hdr[4];
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;

      // Single word, directed payload 0x11223344
      run_image(1, 0, -1, 0, 1, 32'h1122_3344);
      // Wait states on every phase, three words (last address wraps past 2^32)
      run_image(3, 0, -1, 2, 0, '0);
      // Zero length
      run_image(0, 0, -1, 0, 0, '0);
      // Oversize and largest legal length
      run_image(int'(MAXW) + 1, 0, -1, 0, 0, '0);
      run_image(int'(MAXW), 0, -1, 1, 0, '0);
      // Wrong checksum
      run_image(2, 1, -1, 1, 0, '0);
      // Slave error on the second data phase
      run_image(3, 0, 1, 1, 0, '0);
      // Random images
      for (int t = 0; t < 4; t++)
         run_image($urandom_range(1, 6), 1'($urandom_range(0, 1)), -1,
                   $urandom_range(0, 1), 0, '0);

      // Reset during the second write's address phase
      hready_mode = 2;
      err_at = -1;
      do_reset();
      hdr[0] = 8'h02; hdr[1] = 8'h00; hdr[2] = 8'h00; hdr[3] = 8'h00;
      for (int i = 0; i < 4; i++) send_byte(hdr[i]);
      for (int i = 0; i < 8; i++) send_byte(8'($urandom));
      chk("second_addr_phase", 32'(bus.HTRANS), 32'h2);
      chk("one_write_before_reset", 32'(obs_addr.size()), 32'h1);
      HRESET = 1'b1;
      #1;
      chk("async_rst_htrans", 32'(bus.HTRANS), 32'h0);
      chk("async_rst_rx_ready", 32'(bus.rx_ready), 32'h0);
      chk("async_rst_hwrite", 32'(bus.HWRITE), 32'h0);
      chk("async_rst_haddr", bus.HADDR, BASE);
      run_image(1, 0, -1, 0, 1, 32'hA5C3_0F96);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
